// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// AluShareArbiter (module alu_share_arbiter)
//
// Purpose:
//   Lets two requesters share one external combinational ALU. Examples are the
//   core datapath (req0) and an address/branch helper unit (req1).
//   A round-robin arbiter picks one requester per cycle and drives its operands
//   onto the ALU. The ALU result, tagged with the requester id, then travels
//   through LAT register stages. The last stage is the response register,
//   which feeds a valid/ready response channel.
//   If the consumer holds off (response valid but not ready), the whole
//   pipeline freezes and no new request is granted.
//
// Parameters:
//   XLEN  operand/result width
//   LAT   result register stages after the ALU (legal range 1..4)
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_req0_valid / o_req0_ready       requester 0 handshake
//   i_req0_a, i_req0_b, i_req0_ctl    requester 0 operands and 4-bit ALUCtl
//   i_req1_*, o_req1_ready            identical set for requester 1
//   o_alu_a, o_alu_b, o_alu_ctl       operands driven to the shared ALU
//   i_alu_result                      combinational result back from the ALU
//   o_rsp_valid / i_rsp_ready         response channel handshake
//   o_rsp_id, o_rsp_data              requester tag and ALU result
//   o_busy                            any pipeline stage holds a valid op
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int LAT  = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [XLEN-1:0] i_req0_a,
    input  logic [XLEN-1:0] i_req0_b,
    input  logic [3:0]      i_req0_ctl,

    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [XLEN-1:0] i_req1_a,
    input  logic [XLEN-1:0] i_req1_b,
    input  logic [3:0]      i_req1_ctl,

    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [3:0]      o_alu_ctl,
    input  logic [XLEN-1:0] i_alu_result,

    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [XLEN-1:0] o_rsp_data,

    output logic            o_busy
);

    // Pipeline stage state; index 0 is the stage right after the ALU and
    // index LAT-1 is the response register.
    logic [LAT-1:0]  r_valid;
    logic [LAT-1:0]  r_id;
    logic [XLEN-1:0] r_data [LAT];

    // Round-robin pointer: 0 prefers requester 0, 1 prefers requester 1.
    logic            r_ptr;

    logic            w_stall;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt_any;

    // A response that is offered but not taken freezes every stage. When the
    // consumer takes it, the last stage frees up in the same cycle, so a new
    // grant can still happen.
    assign w_stall = r_valid[LAT-1] & ~i_rsp_ready;

    // Grant selection. A lone valid requester always wins. When both are
    // valid, the pointer breaks the tie. Reset also forces ready low,
    // so nothing looks accepted while the block is held in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst && !w_stall) begin
            if (i_req0_valid && (!i_req1_valid || !r_ptr)) begin
                w_gnt0 = 1'b1;
            end else if (i_req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_gnt_any    = w_gnt0 | w_gnt1;
    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    // Operand mux toward the shared ALU. Idle cycles drive zeros so the ALU
    // inputs do not toggle with whatever the requesters leave on their buses.
    always_comb begin
        o_alu_a   = '0;
        o_alu_b   = '0;
        o_alu_ctl = '0;
        if (w_gnt0) begin
            o_alu_a   = i_req0_a;
            o_alu_b   = i_req0_b;
            o_alu_ctl = i_req0_ctl;
        end else if (w_gnt1) begin
            o_alu_a   = i_req1_a;
            o_alu_b   = i_req1_b;
            o_alu_ctl = i_req1_ctl;
        end
    end

    // After a grant, the pointer moves to the requester that lost.
    // It does not move in cycles without a grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    // Result pipeline. Each unstalled cycle, every stage shifts one step,
    // bubbles included, and stage 0 captures the result of this cycle's grant.
    // A bubble loads zero data so the response bus is quiet when idle.
    // Reset clears the stages, so any op in flight is dropped and never
    // produces a response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_id    <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_gnt_any;
            r_id[0]    <= w_gnt1;
            r_data[0]  <= w_gnt_any ? i_alu_result : '0;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_id[k]    <= r_id[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    // The response channel is the last stage. It holds its value during a
    // stall because nothing advances.
    assign o_rsp_valid = r_valid[LAT-1];
    assign o_rsp_id    = r_id[LAT-1];
    assign o_rsp_data  = r_data[LAT-1];
    assign o_busy      = |r_valid;

endmodule
